// File: rtl/axi_lite_intr_ctrl.sv
// AXI4-Lite interrupt controller: captures up to 32 edge/level sources into
// ISR and drives one registered irq line gated by IER and GIE.
//
// state  | meaning
// W_IDLE | waiting for AW and W together; both are accepted in one cycle
// W_RESP | BVALID held until the master takes the response
// R_IDLE | waiting for AR
// R_DATA | RVALID/RDATA held until the master takes the data
module axi_lite_intr_ctrl #(
  parameter int          C_NUM_OF_INTR       = 1,
  parameter int          C_S_AXI_DATA_WIDTH  = 32,
  parameter int          C_S_AXI_ADDR_WIDTH  = 5,
  parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFF_FFFF,
  parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFF_FFFF,
  parameter logic        C_IRQ_ACTIVE_STATE  = 1'b1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]          intr_in,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              irq
);

  localparam int N = C_NUM_OF_INTR;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic         gie;
  logic [N-1:0] ier, isr, intr_d;
  logic [N-1:0] isr_set, iar_clr, ier_nxt;
  logic         wr_hs, rd_hs;
  logic [2:0]   wr_sel, rd_sel;
  logic [31:0]  rd_mux, ier_ext, isr_ext, ipr_ext;
  logic         unused_ok;

  assign wr_sel = S_AXI_AWADDR[4:2];
  assign rd_sel = S_AXI_ARADDR[4:2];
  assign wr_hs  = (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = (r_state == R_IDLE) && S_AXI_ARVALID;

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR,
                       S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

  // write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // write FSM next state
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (wr_hs) w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // write FSM outputs; AW and W are only ever accepted together
  always_comb begin
    S_AXI_AWREADY = wr_hs;
    S_AXI_WREADY  = wr_hs;
    S_AXI_BVALID  = (w_state == W_RESP);
  end

  // read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // read FSM next state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (rd_hs) r_state_nxt = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // read FSM outputs
  always_comb begin
    S_AXI_ARREADY = rd_hs;
    S_AXI_RVALID  = (r_state == R_DATA);
  end

  // per-source event detection, IAR clear mask and strobed IER update
  always_comb begin
    isr_set = '0;
    iar_clr = '0;
    ier_nxt = ier;
    for (int i = 0; i < N; i++) begin
      if (C_INTR_SENSITIVITY[i])
        isr_set[i] = C_INTR_ACTIVE_STATE[i] ? (intr_in[i] & ~intr_d[i])
                                            : (~intr_in[i] & intr_d[i]);
      else
        isr_set[i] = (intr_in[i] == C_INTR_ACTIVE_STATE[i]);
      if (wr_hs && wr_sel == 3'd3 && S_AXI_WSTRB[i/8])
        iar_clr[i] = S_AXI_WDATA[i];
      if (wr_hs && wr_sel == 3'd1 && S_AXI_WSTRB[i/8])
        ier_nxt[i] = S_AXI_WDATA[i];
    end
  end

  // register file and status capture; a same-cycle event beats an ack
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gie    <= 1'b0;
      ier    <= '0;
      isr    <= '0;
      intr_d <= '0;
    end else begin
      intr_d <= intr_in;
      isr    <= (isr & ~iar_clr) | isr_set;
      ier    <= ier_nxt;
      if (wr_hs && wr_sel == 3'd0 && S_AXI_WSTRB[0]) gie <= S_AXI_WDATA[0];
    end
  end

  // read data select, zero-extended to the bus width
  always_comb begin
    ier_ext = '0;
    isr_ext = '0;
    ipr_ext = '0;
    ier_ext[N-1:0] = ier;
    isr_ext[N-1:0] = isr;
    ipr_ext[N-1:0] = isr & ier;
    case (rd_sel)
      3'd0:    rd_mux = {31'd0, gie};
      3'd1:    rd_mux = ier_ext;
      3'd2:    rd_mux = isr_ext;
      3'd4:    rd_mux = ipr_ext;
      default: rd_mux = '0;
    endcase
  end

  // read data captured at the AR handshake and held while RVALID
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   S_AXI_RDATA <= '0;
    else if (rd_hs) S_AXI_RDATA <= rd_mux;
  end

  // registered interrupt output
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) irq <= ~C_IRQ_ACTIVE_STATE;
    else          irq <= (gie && |(isr & ier)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
  end

endmodule
